scaler_ctrl: RTL and testbench

Frame-synchronous configuration controller for the video scaler datapath (crop, line FIFO, stream scaler). It accepts a crop window and output-resolution request through a valid/ready handshake and validates it. It computes the Q4.14 x/y scale factors with a shared serial divider, replacing the wide combinational divide. The new configuration is committed atomically on the next input vsync rising edge, together with the per-frame scaler start pulse.

---
 rtl/scaler_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_scaler_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scaler_ctrl.sv
// Video scaler configuration controller: validates a crop/output request, derives the
// Q4.14 scale factors with one shared serial divider, and commits on the next vsync edge.
module scaler_ctrl #(
   parameter int unsigned INPUT_X_RES_WIDTH  = 11,
   parameter int unsigned INPUT_Y_RES_WIDTH  = 11,
   parameter int unsigned OUTPUT_X_RES_WIDTH = 11,
   parameter int unsigned OUTPUT_Y_RES_WIDTH = 11,
   parameter int unsigned SCALE_INT_BITS     = 4,
   parameter int unsigned SCALE_FRAC_BITS    = 14
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         cfg_valid,
   output logic                                         cfg_ready,
   input  logic [INPUT_X_RES_WIDTH-1:0]                 start_x,
   input  logic [INPUT_X_RES_WIDTH-1:0]                 end_x,
   input  logic [INPUT_Y_RES_WIDTH-1:0]                 start_y,
   input  logic [INPUT_Y_RES_WIDTH-1:0]                 end_y,
   input  logic [OUTPUT_X_RES_WIDTH-1:0]                out_x_res,
   input  logic [OUTPUT_Y_RES_WIDTH-1:0]                out_y_res,
   input  logic                                         nearest_sel,
   input  logic                                         vs_i,
   output logic                                         cfg_error,
   output logic                                         busy,
   output logic                                         scaler_start,
   output logic [INPUT_X_RES_WIDTH-1:0]                 input_x_res,
   output logic [INPUT_Y_RES_WIDTH-1:0]                 input_y_res,
   output logic [OUTPUT_X_RES_WIDTH-1:0]                output_x_res,
   output logic [OUTPUT_Y_RES_WIDTH-1:0]                output_y_res,
   output logic [SCALE_INT_BITS+SCALE_FRAC_BITS-1:0]    x_scale,
   output logic [SCALE_INT_BITS+SCALE_FRAC_BITS-1:0]    y_scale,
   output logic                                         nearest_neighbor
);

   localparam int unsigned SCALE_BITS = SCALE_INT_BITS + SCALE_FRAC_BITS;
   localparam int unsigned IN_W  = (INPUT_X_RES_WIDTH > INPUT_Y_RES_WIDTH) ?
                                   INPUT_X_RES_WIDTH : INPUT_Y_RES_WIDTH;
   localparam int unsigned OUT_W = (OUTPUT_X_RES_WIDTH > OUTPUT_Y_RES_WIDTH) ?
                                   OUTPUT_X_RES_WIDTH : OUTPUT_Y_RES_WIDTH;
   localparam int unsigned DVD_W = IN_W + SCALE_FRAC_BITS + 1;
   localparam int unsigned DVS_W = OUT_W + 1;
   localparam int unsigned CNT_W = $clog2(DVD_W);

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      DIV_X,
      DIV_Y,
      PEND
   } state_t;

   state_t state, state_next;

   // shadow copy of the request and its derived values, held until commit
   logic [INPUT_X_RES_WIDTH-1:0]  sh_start_x, sh_end_x, sh_in_x;
   logic [INPUT_Y_RES_WIDTH-1:0]  sh_start_y, sh_end_y, sh_in_y;
   logic [OUTPUT_X_RES_WIDTH-1:0] sh_out_x;
   logic [OUTPUT_Y_RES_WIDTH-1:0] sh_out_y;
   logic                          sh_nearest;
   logic [SCALE_BITS-1:0]         sh_x_scale, sh_y_scale;

   logic [DVD_W-1:0]              dvd, quo, quo_next;
   logic [DVS_W-1:0]              dvs, rem;
   logic [DVS_W:0]                trial;
   logic                          qbit;
   logic [CNT_W-1:0]              cnt;
   logic                          div_last;
   logic [SCALE_BITS-1:0]         div_result;

   logic [INPUT_X_RES_WIDTH-1:0]  span_x;
   logic [INPUT_Y_RES_WIDTH-1:0]  span_y;
   logic                          crop_bad;
   logic                          vs_q, vs_edge;
   logic                          loaded;
   logic                          accept, commit, load_x, load_y;

   // request validation, vsync edge detect and one restoring-divider step
   always_comb begin
      span_x     = sh_end_x - sh_start_x;
      span_y     = sh_end_y - sh_start_y;
      crop_bad   = (sh_end_x <= sh_start_x) || (sh_end_y <= sh_start_y);
      vs_edge    = vs_i & ~vs_q;
      trial      = {rem, dvd[DVD_W-1]};
      qbit       = (trial >= {1'b0, dvs});
      quo_next   = {quo[DVD_W-2:0], qbit};
      div_last   = (cnt == CNT_W'(DVD_W - 1));
      div_result = (|quo_next[DVD_W-1:SCALE_BITS]) ? '1 : quo_next[SCALE_BITS-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      commit     = 1'b0;
      load_x     = 1'b0;
      load_y     = 1'b0;
      case (state)
         IDLE: begin
            if (cfg_valid) begin
               accept     = 1'b1;
               state_next = CHECK;
            end
         end
         CHECK: begin
            if (crop_bad) begin
               state_next = IDLE;
            end else begin
               load_x     = 1'b1;
               state_next = DIV_X;
            end
         end
         DIV_X: begin
            if (div_last) begin
               load_y     = 1'b1;
               state_next = DIV_Y;
            end
         end
         DIV_Y: begin
            if (div_last) state_next = PEND;
         end
         PEND: begin
            if (vs_edge) begin
               commit     = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // request capture and derived crop sizes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_start_x <= '0;
         sh_end_x   <= '0;
         sh_start_y <= '0;
         sh_end_y   <= '0;
         sh_out_x   <= '0;
         sh_out_y   <= '0;
         sh_nearest <= 1'b0;
         sh_in_x    <= '0;
         sh_in_y    <= '0;
      end else begin
         if (accept) begin
            sh_start_x <= start_x;
            sh_end_x   <= end_x;
            sh_start_y <= start_y;
            sh_end_y   <= end_y;
            sh_out_x   <= out_x_res;
            sh_out_y   <= out_y_res;
            sh_nearest <= nearest_sel;
         end
         if (load_x) begin
            sh_in_x <= span_x - INPUT_X_RES_WIDTH'(1);
            sh_in_y <= span_y - INPUT_Y_RES_WIDTH'(1);
         end
      end
   end

   // shared divider: x axis first, then reloaded for y; quotient MSB first
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dvd        <= '0;
         dvs        <= '0;
         rem        <= '0;
         quo        <= '0;
         cnt        <= '0;
         sh_x_scale <= '0;
         sh_y_scale <= '0;
      end else if (load_x) begin
         dvd <= DVD_W'(span_x) << SCALE_FRAC_BITS;
         dvs <= DVS_W'(sh_out_x) + DVS_W'(1);
         rem <= '0;
         quo <= '0;
         cnt <= '0;
      end else if (load_y) begin
         dvd        <= DVD_W'(span_y) << SCALE_FRAC_BITS;
         dvs        <= DVS_W'(sh_out_y) + DVS_W'(1);
         rem        <= '0;
         quo        <= '0;
         cnt        <= '0;
         sh_x_scale <= div_result;
      end else if (state == DIV_X || state == DIV_Y) begin
         dvd <= dvd << 1;
         quo <= quo_next;
         cnt <= cnt + CNT_W'(1);
         rem <= qbit ? DVS_W'(trial - {1'b0, dvs}) : DVS_W'(trial);
         if (state == DIV_Y && div_last) sh_y_scale <= div_result;
      end
   end

   // handshake/status flags, frame start and the atomic commit of the active config
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vs_q             <= 1'b0;
         loaded           <= 1'b0;
         cfg_ready        <= 1'b1;
         busy             <= 1'b0;
         cfg_error        <= 1'b0;
         scaler_start     <= 1'b0;
         input_x_res      <= '0;
         input_y_res      <= '0;
         output_x_res     <= '0;
         output_y_res     <= '0;
         x_scale          <= '0;
         y_scale          <= '0;
         nearest_neighbor <= 1'b0;
      end else begin
         vs_q         <= vs_i;
         cfg_ready    <= (state_next == IDLE);
         busy         <= (state_next != IDLE);
         cfg_error    <= (state == CHECK) && crop_bad;
         scaler_start <= vs_edge && (loaded || state == PEND);
         if (commit) begin
            loaded           <= 1'b1;
            input_x_res      <= sh_in_x;
            input_y_res      <= sh_in_y;
            output_x_res     <= sh_out_x;
            output_y_res     <= sh_out_y;
            x_scale          <= sh_x_scale;
            y_scale          <= sh_y_scale;
            nearest_neighbor <= sh_nearest;
         end
      end
   end

endmodule

// File: tb/tb_scaler_ctrl.sv
// Scoreboard bench for scaler_ctrl: the driver pushes expected frame starts and rejects
// from an arithmetic reference model; a negedge monitor pops and compares them.
module tb_scaler_ctrl;

   localparam int unsigned XW = 11;
   localparam int unsigned YW = 11;
   localparam int unsigned SB = 18;
   localparam int          PEND_LAT = 54;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg_valid = 1'b0;
   logic          cfg_ready;
   logic [XW-1:0] start_x = '0, end_x = '0;
   logic [YW-1:0] start_y = '0, end_y = '0;
   logic [XW-1:0] out_x_res = '0;
   logic [YW-1:0] out_y_res = '0;
   logic          nearest_sel = 1'b0;
   logic          vs_i = 1'b0;
   logic          cfg_error, busy, scaler_start;
   logic [XW-1:0] input_x_res, output_x_res;
   logic [YW-1:0] input_y_res, output_y_res;
   logic [SB-1:0] x_scale, y_scale;
   logic          nearest_neighbor;

   scaler_ctrl dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .start_x(start_x), .end_x(end_x), .start_y(start_y), .end_y(end_y),
      .out_x_res(out_x_res), .out_y_res(out_y_res), .nearest_sel(nearest_sel),
      .vs_i(vs_i), .cfg_error(cfg_error), .busy(busy), .scaler_start(scaler_start),
      .input_x_res(input_x_res), .input_y_res(input_y_res),
      .output_x_res(output_x_res), .output_y_res(output_y_res),
      .x_scale(x_scale), .y_scale(y_scale), .nearest_neighbor(nearest_neighbor)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int in_x, in_y, out_x, out_y, xs, ys, nn;
   } cfg_t;

   typedef struct {
      cfg_t c;
      int   e;
   } start_t;

   start_t start_q[$];
   int     err_q[$];
   cfg_t   active, pend;
   bit     loaded, pend_valid;
   int     pend_acc;
   int     checks = 0;
   int     errors = 0;
   start_t mon_s;
   int     acc;

   function automatic void chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at edge %0d",
                  name, act, act, exp, exp, cyc);
      end
   endfunction

   function automatic int ref_scale(int span, int outr);
      longint q;
      q = (longint'(span) * 64'd16384) / longint'(outr + 1);
      return (q > 262143) ? 262143 : int'(q);
   endfunction

   function automatic void model_reset();
      active     = '{0, 0, 0, 0, 0, 0, 0};
      loaded     = 1'b0;
      pend_valid = 1'b0;
   endfunction

   // vsync edge sampled at edge e: commit if the pending config has reached PEND
   function automatic void model_edge(int e);
      start_t s;
      if (pend_valid && e >= pend_acc + PEND_LAT) begin
         active     = pend;
         loaded     = 1'b1;
         pend_valid = 1'b0;
      end
      if (loaded) begin
         s.c = active;
         s.e = e;
         start_q.push_back(s);
      end
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (scaler_start) begin
            if (start_q.size() == 0) begin
               chk("unexpected_scaler_start", int'(scaler_start), 0);
            end else begin
               mon_s = start_q.pop_front();
               chk("start_edge", cyc, mon_s.e);
               chk("input_x_res", int'(input_x_res), mon_s.c.in_x);
               chk("input_y_res", int'(input_y_res), mon_s.c.in_y);
               chk("output_x_res", int'(output_x_res), mon_s.c.out_x);
               chk("output_y_res", int'(output_y_res), mon_s.c.out_y);
               chk("x_scale", int'(x_scale), mon_s.c.xs);
               chk("y_scale", int'(y_scale), mon_s.c.ys);
               chk("nearest_neighbor", int'(nearest_neighbor), mon_s.c.nn);
            end
         end
         if (cfg_error) begin
            if (err_q.size() == 0) chk("unexpected_cfg_error", int'(cfg_error), 0);
            else                   chk("cfg_error_edge", cyc, err_q.pop_front());
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_active(input string tag);
      chk({tag, "_input_x_res"}, int'(input_x_res), active.in_x);
      chk({tag, "_input_y_res"}, int'(input_y_res), active.in_y);
      chk({tag, "_output_x_res"}, int'(output_x_res), active.out_x);
      chk({tag, "_output_y_res"}, int'(output_y_res), active.out_y);
      chk({tag, "_x_scale"}, int'(x_scale), active.xs);
      chk({tag, "_y_scale"}, int'(y_scale), active.ys);
      chk({tag, "_nearest"}, int'(nearest_neighbor), active.nn);
   endtask

   // present a request, wait (bounded) for acceptance, update the model
   task automatic send_cfg(input int sx, input int ex, input int sy, input int ey,
                           input int ox, input int oy, input int nn, output int a);
      int n;
      start_x = XW'(sx); end_x = XW'(ex); start_y = YW'(sy); end_y = YW'(ey);
      out_x_res = XW'(ox); out_y_res = YW'(oy); nearest_sel = nn[0];
      cfg_valid = 1'b1;
      n = 0;
      a = -1;
      forever begin
         @(negedge clk);
         if (cfg_ready) break;
         n++;
         if (n > 300) break;
      end
      if (!cfg_ready) begin
         chk("cfg_ready_timeout", int'(cfg_ready), 1);
         @(posedge clk);
         #1 cfg_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         cfg_valid = 1'b0;
         a = cyc;
         chk("busy_after_accept", int'(busy), 1);
         chk("ready_after_accept", int'(cfg_ready), 0);
         if (ex <= sx || ey <= sy) begin
            err_q.push_back(a + 1);
         end else begin
            pend.in_x  = ex - sx - 1;
            pend.in_y  = ey - sy - 1;
            pend.out_x = ox;
            pend.out_y = oy;
            pend.xs    = ref_scale(ex - sx, ox);
            pend.ys    = ref_scale(ey - sy, oy);
            pend.nn    = nn;
            pend_valid = 1'b1;
            pend_acc   = a;
         end
      end
   endtask

   // vsync high sampled first at edge e, held for 'hold' samples, then a low sample
   task automatic vs_at(input int e, input int hold);
      while (cyc < e - 1) step(1);
      vs_i = 1'b1;
      model_edge(cyc + 1);
      step(hold);
      vs_i = 1'b0;
      step(1);
   endtask

   task automatic commit_now();
      int e;
      e = pend_acc + PEND_LAT + int'($urandom_range(0, 4));
      if (e < cyc + 1) e = cyc + 1;
      vs_at(e, int'($urandom_range(1, 3)));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int sx, ex, sy, ey, ox, oy, nn, k;
      model_reset();
      step(3);
      rst = 1'b0;
      step(1);

      // reset state, and no frame start before the first commit
      chk("reset_cfg_ready", int'(cfg_ready), 1);
      chk("reset_busy", int'(busy), 0);
      chk("reset_start", int'(scaler_start), 0);
      chk("reset_error", int'(cfg_error), 0);
      check_active("reset");
      vs_at(cyc + 2, 1);
      vs_at(cyc + 3, 2);

      // upscale 640x480 -> 1280x960
      send_cfg(0, 640, 0, 480, 1279, 959, 0, acc);
      vs_at(acc + 60, 1);
      chk("upscale_busy_low", int'(busy), 0);
      chk("upscale_x_scale", int'(x_scale), 32'h2000);

      // downscale 1920x1080 -> 960x540; edge one cycle before PEND must not commit
      send_cfg(0, 1920, 0, 1080, 959, 539, 1, acc);
      vs_at(acc + PEND_LAT - 1, 1);
      chk("pre_pend_busy", int'(busy), 1);
      vs_at(cyc + 1, 1);
      chk("downscale_y_scale", int'(y_scale), 32'h8000);

      // saturation; edge exactly at PEND entry commits
      send_cfg(0, 2047, 0, 2047, 0, 0, 1, acc);
      vs_at(acc + PEND_LAT, 2);
      chk("sat_x_scale", int'(x_scale), 32'h3FFFF);

      // reject: zero-width crop
      send_cfg(100, 100, 0, 480, 639, 479, 0, acc);
      step(4);
      chk("reject_ready", int'(cfg_ready), 1);
      check_active("reject");
      vs_at(cyc + 2, 1);

      // atomic commit: A active while B divides, vsync edges in between
      send_cfg(0, 640, 0, 480, 1279, 959, 0, acc);
      vs_at(acc + 58, 1);
      send_cfg(10, 500, 20, 300, 399, 199, 1, acc);
      vs_at(acc + 3, 1);
      vs_at(acc + 9, 3);
      check_active("during_div");
      vs_at(acc + 60, 1);

      // randomized requests with random vsync timing
      for (int it = 0; it < 25; it++) begin
         sx = int'($urandom_range(0, 1500));
         ex = int'($urandom_range(sx + 1, 2047));
         sy = int'($urandom_range(0, 1500));
         ey = int'($urandom_range(sy + 1, 2047));
         if ($urandom_range(0, 5) == 0) ex = int'($urandom_range(0, sx));
         if ($urandom_range(0, 7) == 0) ey = int'($urandom_range(0, sy));
         ox = int'($urandom_range(0, 2047));
         oy = int'($urandom_range(0, 2047));
         nn = int'($urandom_range(0, 1));
         send_cfg(sx, ex, sy, ey, ox, oy, nn, acc);
         k = int'($urandom_range(0, 2));
         for (int j = 0; j < k; j++) vs_at(cyc + 1 + int'($urandom_range(0, 15)),
                                          int'($urandom_range(1, 3)));
         if (pend_valid) commit_now();
         else            step(3);
      end

      // reset during DIV_Y discards everything
      send_cfg(0, 800, 0, 600, 399, 299, 1, acc);
      while (cyc < acc + 35) step(1);
      rst = 1'b1;
      model_reset();
      step(2);
      check_active("in_reset");
      rst = 1'b0;
      step(1);
      chk("post_rst_ready", int'(cfg_ready), 1);
      chk("post_rst_busy", int'(busy), 0);
      check_active("post_rst");
      vs_at(cyc + 2, 1);
      vs_at(cyc + 40, 1);

      step(5);
      chk("start_q_drained", start_q.size(), 0);
      chk("err_q_drained", err_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
